// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell + registered borrow.
// Latency: start accepted at edge E0 -> busy after E0..E0+WIDTH, done pulse the cycle after E0+WIDTH.
// Backpressure: start is sampled only in IDLE; requests while SHIFT/DONE are dropped, not queued.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           operation request (IDLE only)
//   a, b, bin       minuend, subtrahend, borrow-in; captured on the accepted start edge
//   busy            high while bits are being shifted
//   done            one-cycle pulse; diff/bout are final
//   diff, bout      registered difference and borrow-out
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             d;
   logic             nb;

   // Full-subtractor cell on the current LSBs.
   assign d  = op_a[0] ^ op_b[0] ^ br;
   assign nb = (~op_a[0] & op_b[0]) | (~(op_a[0] ^ op_b[0]) & br);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // busy/done are pure state decodes, so no input ever reaches an output combinationally.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (cnt == LAST) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a <= '0;
         op_b <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         diff <= '0;
         bout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // diff/bout are left alone here so the previous result stays visible.
               if (start) begin
                  op_a <= a;
                  op_b <= b;
                  br   <= bin;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               diff <= {d, diff[WIDTH-1:1]};
               op_a <= {1'b0, op_a[WIDTH-1:1]};
               op_b <= {1'b0, op_b[WIDTH-1:1]};
               br   <= nb;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  bout <= nb;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         bin   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;

   int           passed = 0;
   int           total  = 0;
   logic [W-1:0] last_diff = '0;
   logic         last_bout = 1'b0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic, result wrapped to W bits; borrow iff negative.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
      int           r;
      logic [W-1:0] ed;
      logic         eb;
      r  = int'(ta) - int'(tb_v) - int'(tbin);
      ed = r[W-1:0];
      eb = (r < 0);
      a = ta; b = tb_v; bin = tbin; start = 1'b1;
      tick;
      start = 1'b0;
      chk("hold_diff_before_shift", 32'(diff), 32'(last_diff));
      chk("hold_bout_before_shift", 32'(bout), 32'(last_bout));
      for (int i = 0; i < W; i++) begin
         chk("busy_during_shift", 32'(busy), 32'd1);
         chk("no_done_during_shift", 32'(done), 32'd0);
         tick;
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_low_at_done", 32'(busy), 32'd0);
      chk("diff", 32'(diff), 32'(ed));
      chk("bout", 32'(bout), 32'(eb));
      tick;
      chk("done_one_cycle", 32'(done), 32'd0);
      last_diff = ed;
      last_bout = eb;
   endtask

   initial begin
      int ndone;
      int last_cyc;

      // Reset state
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_bout", 32'(bout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed arithmetic cases
      run_op(8'd100, 8'd58, 1'b0);
      run_op(8'd5, 8'd9, 1'b0);
      run_op(8'd0, 8'd0, 1'b1);
      run_op(8'hFF, 8'hFF, 1'b0);
      run_op(8'h80, 8'h01, 1'b1);
      run_op(8'h00, 8'hFF, 1'b1);

      // start re-pulsed while busy is ignored
      a = 8'd20; b = 8'd7; bin = 1'b0; start = 1'b1;
      tick;
      start = 1'b0;
      repeat (3) tick;
      start = 1'b1; a = 8'd1; b = 8'd2;
      tick;
      start = 1'b0;
      repeat (W - 4) tick;
      chk("busy_test_done", 32'(done), 32'd1);
      chk("busy_test_diff", 32'(diff), 32'd13);
      chk("busy_test_bout", 32'(bout), 32'd0);
      ndone = 0;
      for (int i = 0; i < 2 * W; i++) begin
         tick;
         if (done) ndone++;
      end
      chk("busy_test_no_extra_done", 32'(ndone), 32'd0);
      chk("busy_test_diff_holds", 32'(diff), 32'd13);
      last_diff = 8'd13;
      last_bout = 1'b0;

      // Asynchronous reset mid-operation (during bit 4)
      a = 8'd200; b = 8'd100; bin = 1'b0; start = 1'b1;
      tick;
      start = 1'b0;
      repeat (4) tick;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_diff", 32'(diff), 32'd0);
      chk("midrst_bout", 32'(bout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 2 * W; i++) begin
         tick;
         if (done || busy) ndone++;
      end
      chk("midrst_no_activity_after", 32'(ndone), 32'd0);
      last_diff = '0;
      last_bout = 1'b0;
      run_op(8'd3, 8'd1, 1'b0);

      // Randomized operands
      for (int n = 0; n < 20; n++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom));
      end

      // Continuous start: back-to-back ops every W+2 cycles
      a = 8'd10; b = 8'd3; bin = 1'b0; start = 1'b1;
      ndone    = 0;
      last_cyc = -1;
      for (int cyc = 0; cyc < 4 * (W + 2) + 1; cyc++) begin
         tick;
         chk("busy_done_exclusive", 32'(busy & done), 32'd0);
         if (done) begin
            ndone++;
            chk("cont_diff", 32'(diff), 32'd7);
            chk("cont_bout", 32'(bout), 32'd0);
            if (last_cyc >= 0) chk("cont_period", 32'(cyc - last_cyc), 32'(W + 2));
            last_cyc = cyc;
         end
      end
      start = 1'b0;
      chk("cont_done_count", 32'(ndone), 32'd4);
      repeat (W + 3) tick;
      chk("idle_at_end", 32'(busy | done), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes diff = a - b - bin, one bit per clock, LSB first.
- Uses a single full-subtractor cell and a registered borrow.
- Serves as the subtraction counterpart to the team's combinational full-adder cell, for area-constrained datapaths where multi-cycle latency is acceptable.
- Uses a start/busy/done handshake with operand capture.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2

Ports:
clk   input  1      rising-edge clock
rst_n input  1      asynchronous active-low reset
start input  1      request; sampled only in IDLE
a     input  WIDTH  minuend; captured on the accepted start edge
b     input  WIDTH  subtrahend; captured on the accepted start edge
bin   input  1      borrow-in; captured on the accepted start edge
busy  output 1      high while in SHIFT
done  output 1      one-cycle pulse; diff and bout are final
diff  output WIDTH  difference, registered
bout  output 1      borrow-out, registered

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous and active-low.
  - While rst_n=0: state=IDLE, busy=0, done=0, diff=0, bout=0, internal shift registers, borrow and counter=0.
  - Reset asserted mid-operation aborts the operation. No done is produced, and state is IDLE after release.
- States: IDLE, SHIFT, DONE. Registers are opA, opB (WIDTH), br (1), cnt (clog2(WIDTH+1) bits).
- IDLE:
  - busy=0, done=0.
  - On a rising edge with start=1: opA<=a, opB<=b, br<=bin, cnt<=0, state<=SHIFT.
  - diff and bout keep their previous values until the first SHIFT edge.
- SHIFT, each edge:
  - d = opA[0] ^ opB[0] ^ br.
  - nb = (~opA[0] & opB[0]) | (~(opA[0] ^ opB[0]) & br).
  - diff <= {d, diff[WIDTH-1:1]}; opA and opB shift right by one; br <= nb; cnt <= cnt+1.
  - When cnt == WIDTH-1 on that edge: bout <= nb and state <= DONE.
  - diff is partial and not valid while busy=1.
- DONE:
  - done=1 and busy=0 for exactly one cycle; state<=IDLE on the next edge.
  - diff and bout hold their final values until the next accepted start's first SHIFT edge.
- Latency:
  - Start accepted at edge E0 gives busy=1 after E0 through edge E0+WIDTH.
  - done=1 in the cycle following edge E0+WIDTH.
  - Next start can be accepted at edge E0+WIDTH+2 at the earliest.
- start while in SHIFT or DONE is ignored. It is not queued, and a/b/bin changes in those states have no effect.
- start held high continuously causes back-to-back operations, one accepted each time IDLE is re-entered.
- Arithmetic:
  - Modulo 2^WIDTH: diff = (a - b - bin) mod 2^WIDTH.
  - bout=1 iff a < b + bin when treated as unsigned (WIDTH+1)-bit values.
- busy and done are never high simultaneously. done is never high in IDLE or SHIFT.
- All outputs are driven directly from registers or from the state decode, with no combinational path from inputs.

Test Plan:
- Reset, then WIDTH=8, a=100, b=58, bin=0, pulse start -> busy high for 8 cycles, done pulses 8 cycles after the accept edge, diff=42, bout=0.
- a=5, b=9, bin=0 -> diff=8'hFC (252), bout=1. Then a=0, b=0, bin=1 -> diff=8'hFF, bout=1.
- a=8'hFF, b=8'hFF, bin=0 -> diff=0, bout=0. Then a=8'h80, b=8'h01, bin=1 -> diff=8'h7E, bout=0.
- Busy handling: start a=20, b=7, then re-pulse start with a=1, b=2 while busy -> second request ignored, diff=13, bout=0. Exactly one done pulse, and diff holds 13 until the next accept.
- Reset mid-operation: start a=200, b=100, assert rst_n=0 asynchronously at bit 4 -> busy, done, diff and bout go 0 immediately. After release, no done pulse; a fresh start with a=3, b=1 gives diff=2.
- Continuous start: hold start high with a=10, b=3 -> done pulses every WIDTH+2 cycles, each with diff=7, bout=0. Also check busy and done are never simultaneously high.
